// File: rtl/key_exp_inv_128_if.sv
// Handshake bundle between the inverse AES-128 key schedule and its consumer.
interface key_exp_inv_128_if;
  logic         enable;
  logic         key_ack;
  logic [127:0] key;
  logic         key_ready;
  logic [3:0]   key_round;
  logic [127:0] key_out;
  logic         busy;
  logic         o_state_error;

  modport master (
    output enable, key_ack, key,
    input  key_ready, key_round, key_out, busy, o_state_error
  );

  modport slave (
    input  enable, key_ack, key,
    output key_ready, key_round, key_out, busy, o_state_error
  );
endinterface

// File: rtl/key_exp_inv_128.sv
// Decryption-side AES-128 key schedule: expands to round 10, then walks back
// one round per accepted key so round keys come out 10 down to 0.
package key_exp_inv_128_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    FWD     = 3'b010,
    PRESENT = 3'b100
  } state_t;
endpackage

module key_exp_inv_128 #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  key_exp_inv_128_if.slave bus
);
  import key_exp_inv_128_pkg::*;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so byte b lives at bit offset (255-b)*8.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] g_word(input logic [31:0] x, input logic [3:0] r);
    logic [31:0] rot;
    logic [31:0] sub;
    rot = {x[23:0], x[31:24]};
    for (int unsigned i = 0; i < 4; i++) begin
      sub[8*i +: 8] = sub_byte(rot[8*i +: 8]);
    end
    return sub ^ {rcon(r), 24'h000000};
  endfunction

  state_t      state_q, state_d;
  logic        enable_q;
  logic        key_ready_q, key_ready_d;
  logic [3:0]  key_round_q, key_round_d;
  logic [31:0] w0_q, w1_q, w2_q, w3_q;
  logic [31:0] w0_d, w1_d, w2_d, w3_d;
  logic        state_error;
  logic        start;
  logic [31:0] g_in;
  logic [3:0]  g_r;
  logic [31:0] g_out;

  always_comb begin
    state_d     = state_q;
    key_ready_d = key_ready_q;
    key_round_d = key_round_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    w3_d        = w3_q;
    state_error = 1'b0;
    start       = bus.enable & ~enable_q;

    // One g() serves both directions: forward uses w3 with r+1, inverse uses
    // the recovered w3 (w3^w2) with the current round.
    if (state_q == FWD) begin
      g_in = w3_q;
      g_r  = key_round_q + 4'd1;
    end else begin
      g_in = w3_q ^ w2_q;
      g_r  = key_round_q;
    end
    g_out = g_word(g_in, g_r);

    case (state_q)
      IDLE: begin
        if (start) begin
          w0_d        = bus.key[31:0];
          w1_d        = bus.key[63:32];
          w2_d        = bus.key[95:64];
          w3_d        = bus.key[127:96];
          key_round_d = 4'd0;
          state_d     = FWD;
        end
      end
      FWD: begin
        w0_d        = w0_q ^ g_out;
        w1_d        = w1_q ^ w0_d;
        w2_d        = w2_q ^ w1_d;
        w3_d        = w3_q ^ w2_d;
        key_round_d = g_r;
        if (g_r == 4'(NUM_ROUNDS)) begin
          state_d     = PRESENT;
          key_ready_d = 1'b1;
        end
      end
      PRESENT: begin
        if (bus.key_ack) begin
          if (key_round_q != 4'd0) begin
            w3_d        = w3_q ^ w2_q;
            w2_d        = w2_q ^ w1_q;
            w1_d        = w1_q ^ w0_q;
            w0_d        = w0_q ^ g_out;
            key_round_d = key_round_q - 4'd1;
          end else begin
            state_d     = IDLE;
            key_ready_d = 1'b0;
          end
        end
      end
      default: begin
        state_error = 1'b1;
        state_d     = IDLE;
        key_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      enable_q    <= 1'b0;
      key_ready_q <= 1'b0;
      key_round_q <= '0;
      w0_q        <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      w3_q        <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= bus.enable;
      key_ready_q <= key_ready_d;
      key_round_q <= key_round_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      w3_q        <= w3_d;
    end
  end

  assign bus.key_ready     = key_ready_q;
  assign bus.key_round     = key_round_q;
  assign bus.key_out       = {w3_q, w2_q, w1_q, w0_q};
  assign bus.busy          = (state_q != IDLE);
  assign bus.o_state_error = state_error;

endmodule

// File: tb/tb_key_exp_inv_128.sv
// Directed bench for key_exp_inv_128 using the FIPS-197 A.1 key schedule.
module tb_key_exp_inv_128;
  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  key_exp_inv_128_if bus ();

  key_exp_inv_128 #(.NUM_ROUNDS(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  localparam logic [127:0] FIPS_KEY = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
  logic [127:0] exp_key [0:10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_key(input string tag, input int unsigned r);
    chk({tag, "_ready"}, 128'(bus.key_ready), 128'd1);
    chk({tag, "_round"}, 128'(bus.key_round), 128'(r));
    chk({tag, "_key"}, bus.key_out, exp_key[r]);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 128'(bus.key_ready), 128'd0);
    chk({tag, "_round"}, 128'(bus.key_round), 128'd0);
    chk({tag, "_key"}, bus.key_out, 128'd0);
    chk({tag, "_busy"}, 128'(bus.busy), 128'd0);
    chk({tag, "_err"}, 128'(bus.o_state_error), 128'd0);
  endtask

  task automatic start();
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
  endtask

  // Called right after the start edge; key_ready must rise 10 edges later.
  task automatic wait_ready();
    int unsigned n = 0;
    while (bus.key_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("latency", 128'(n), 128'd10);
  endtask

  task automatic drain_all(input string tag);
    bus.key_ack = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      chk_key(tag, 9 - i);
    end
    tick();
    bus.key_ack = 1'b0;
    chk({tag, "_end_ready"}, 128'(bus.key_ready), 128'd0);
    chk({tag, "_end_busy"}, 128'(bus.busy), 128'd0);
  endtask

  initial begin
    exp_key[0]  = FIPS_KEY;
    exp_key[1]  = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
    exp_key[2]  = 128'h7359f67f_5935807a_7a96b943_f2c295f2;
    exp_key[3]  = 128'h6d7a883b_1e237e44_4716fe3e_3d80477d;
    exp_key[4]  = 128'hdb0bad00_b671253b_a8525b7f_ef44a541;
    exp_key[5]  = 128'h11f915bc_caf2b8bc_7c839d87_d4d1c6f8;
    exp_key[6]  = 128'hca0093fd_dbf98641_110b3efd_6d88a37a;
    exp_key[7]  = 128'h4ea6dc4f_84a64fb2_5f5fc9f3_4e54f70e;
    exp_key[8]  = 128'h7f8d292f_312bf560_b58dbad2_ead27321;
    exp_key[9]  = 128'h575c006e_28d12941_19fadc21_ac7766f3;
    exp_key[10] = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;

    bus.enable  = 1'b0;
    bus.key_ack = 1'b0;
    bus.key     = '0;
    reset_n     = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    reset_n = 1'b1;
    tick();
    chk("idle_busy", 128'(bus.busy), 128'd0);

    // Start, then disturb key, enable and ack while the forward pass runs
    bus.key = FIPS_KEY;
    start();
    bus.key = ~FIPS_KEY;
    chk("fwd_busy", 128'(bus.busy), 128'd1);
    chk("fwd_load", bus.key_out, FIPS_KEY);
    chk("fwd_round0", 128'(bus.key_round), 128'd0);
    for (int unsigned k = 1; k <= 9; k++) begin
      bus.enable  = (k == 3);
      bus.key_ack = (k <= 5);
      tick();
      chk("fwd_round", 128'(bus.key_round), 128'(k));
      chk("fwd_not_ready", 128'(bus.key_ready), 128'd0);
    end
    bus.enable  = 1'b0;
    bus.key_ack = 1'b0;
    tick();
    chk_key("first", 10);
    repeat (3) begin
      tick();
      chk_key("hold", 10);
    end

    // Ack held high with enable toggling; final ack coincides with an enable edge
    bus.key_ack = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      bus.enable = ((9 - i) % 2 == 1);
      tick();
      chk_key("stream", 9 - i);
    end
    bus.enable = 1'b1;
    tick();
    bus.key_ack = 1'b0;
    chk("last_ready", 128'(bus.key_ready), 128'd0);
    chk("last_busy", 128'(bus.busy), 128'd0);
    chk("last_key", bus.key_out, FIPS_KEY);
    tick();
    chk("held_enable_busy", 128'(bus.busy), 128'd0);
    bus.enable = 1'b0;
    tick();
    chk("idle_again", 128'(bus.busy), 128'd0);

    // Random gaps between acks
    bus.key = FIPS_KEY;
    start();
    wait_ready();
    for (int unsigned i = 0; i <= 10; i++) begin
      int unsigned gap;
      gap = $urandom_range(0, 5);
      bus.key_ack = 1'b0;
      repeat (gap) begin
        tick();
        chk_key("gap_hold", 10 - i);
      end
      chk_key("gap_key", 10 - i);
      bus.key_ack = 1'b1;
      tick();
    end
    bus.key_ack = 1'b0;
    chk("gap_end_ready", 128'(bus.key_ready), 128'd0);
    chk("gap_end_busy", 128'(bus.busy), 128'd0);

    // Async reset during the forward pass
    start();
    repeat (5) tick();
    chk("pre_reset_round", 128'(bus.key_round), 128'd5);
    reset_n = 1'b0;
    #1;
    chk_reset("reset_fwd");
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk_reset("after_reset_fwd");

    // Async reset while presenting round 4
    start();
    wait_ready();
    bus.key_ack = 1'b1;
    repeat (6) tick();
    bus.key_ack = 1'b0;
    chk_key("pre_reset_present", 4);
    reset_n = 1'b0;
    #1;
    chk_reset("reset_present");
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk_reset("after_reset_present");

    start();
    wait_ready();
    chk_key("restart", 10);
    drain_all("restart");

    // Illegal state encodings
    start();
    wait_ready();
    force dut.state_q = key_exp_inv_128_pkg::state_t'(3'b000);
    #1;
    chk("illegal0_err", 128'(bus.o_state_error), 128'd1);
    release dut.state_q;
    tick();
    chk("illegal0_err_clear", 128'(bus.o_state_error), 128'd0);
    chk("illegal0_busy", 128'(bus.busy), 128'd0);
    chk("illegal0_ready", 128'(bus.key_ready), 128'd0);

    start();
    wait_ready();
    bus.key_ack = 1'b1;
    tick();
    bus.key_ack = 1'b0;
    chk_key("pre_illegal2", 9);
    force dut.state_q = key_exp_inv_128_pkg::state_t'(3'b110);
    #1;
    chk("illegal2_err", 128'(bus.o_state_error), 128'd1);
    release dut.state_q;
    tick();
    chk("illegal2_err_clear", 128'(bus.o_state_error), 128'd0);
    chk("illegal2_busy", 128'(bus.busy), 128'd0);
    chk("illegal2_ready", 128'(bus.key_ready), 128'd0);
    chk("illegal2_round", 128'(bus.key_round), 128'd9);

    start();
    wait_ready();
    chk_key("recover", 10);
    drain_all("recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
